// File: rtl/mult_booth_ctrl_if.sv
// Start/operand/result bundle between a requester and the Booth multiplier controller.
// master drives the operands and start pulse; slave returns the registered result.
interface mult_booth_ctrl_if;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_MULT,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/mult_booth_ctrl.sv
// Sequential radix-4 Booth multiplier: 16 add-and-shift steps per product,
// then the low word, an overflow flag and a one-cycle ready strobe.
module mult_booth_ctrl (
    input  logic              clock,
    input  logic              reset,
    mult_booth_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] m_q;
    logic [33:0] acc_q;
    logic [31:0] qr_q;
    logic        x_q;
    logic [3:0]  cnt_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy;

    logic        start_ok;
    logic        last_step;
    logic [33:0] m_ext;
    logic [33:0] addend;
    logic        cin;
    logic [33:0] sum;
    logic [33:0] step_acc;
    logic [31:0] step_qr;
    logic [63:0] product;
    logic        step_exc;

    // Start is only honoured while no product is in flight.
    always_comb begin
        start_ok  = bus.ctrl_MULT && ((state_q == StIdle) || (state_q == StDone));
        last_step = (state_q == StRun) && (cnt_q == 4'd15);
    end

    // Single Booth step: select the addend from {QR[1:0], X}, add, then shift right by 2.
    always_comb begin
        m_ext  = {{2{m_q[31]}}, m_q};
        addend = '0;
        cin    = 1'b0;
        unique case ({qr_q[1:0], x_q})
            3'b000, 3'b111: begin
                addend = '0;
                cin    = 1'b0;
            end
            3'b001, 3'b010: begin
                addend = m_ext;
                cin    = 1'b0;
            end
            3'b011: begin
                addend = {m_ext[32:0], 1'b0};
                cin    = 1'b0;
            end
            3'b100: begin
                addend = ~{m_ext[32:0], 1'b0};
                cin    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = ~m_ext;
                cin    = 1'b1;
            end
            default: begin
                addend = '0;
                cin    = 1'b0;
            end
        endcase
        sum      = acc_q + addend + {33'd0, cin};
        step_acc = {{2{sum[33]}}, sum[33:2]};
        step_qr  = {sum[1:0], qr_q[31:2]};
        product  = {step_acc[31:0], step_qr};
        // Fits in 32 bits only when bits 63..31 are all copies of the sign.
        step_exc = !((&product[63:31]) || !(|product[63:31]));
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = start_ok ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        rdy = 1'b0;
        if (state_q == StDone) begin
            rdy = 1'b1;
        end
    end

    // Operand, partial product and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q   <= '0;
            acc_q <= '0;
            qr_q  <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else if (start_ok) begin
            m_q   <= bus.data_operandA;
            acc_q <= '0;
            qr_q  <= bus.data_operandB;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            acc_q <= step_acc;
            qr_q  <= step_qr;
            x_q   <= qr_q[1];
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Result registers hold across new starts until the next completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (last_step) begin
            result_q <= product[31:0];
            exc_q    <= step_exc;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy;

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed bench for mult_booth_ctrl: a transaction-level timing/arithmetic model
// checked every cycle, plus literal expectations per vector.
module tb_mult_booth_ctrl;

    logic clock;
    logic reset;
    mult_booth_ctrl_if bus ();

    mult_booth_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests;
    int fails;
    bit chk_en;

    // Model state
    int          cyc;
    bit          busy;
    int          done_edge;
    logic [31:0] pend_res;
    logic        pend_exc;
    logic [31:0] exp_res;
    logic        exp_exc;
    logic        exp_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Product is plain 64-bit signed arithmetic; completion is 16 edges after the start edge.
    always @(posedge clock) begin
        bit          accept;
        longint      p;
        logic [31:0] lo;
        cyc++;
        if (reset) begin
            busy    = 1'b0;
            exp_res = '0;
            exp_exc = 1'b0;
            exp_rdy = 1'b0;
        end else begin
            accept  = bus.ctrl_MULT && !busy;
            exp_rdy = 1'b0;
            if (busy && cyc == done_edge) begin
                exp_res = pend_res;
                exp_exc = pend_exc;
                exp_rdy = 1'b1;
                busy    = 1'b0;
            end
            if (accept) begin
                p         = longint'($signed(bus.data_operandA)) *
                            longint'($signed(bus.data_operandB));
                lo        = p[31:0];
                pend_res  = lo;
                pend_exc  = (p != longint'($signed(lo)));
                busy      = 1'b1;
                done_edge = cyc + 16;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_rdy", {63'd0, bus.data_resultRDY}, {63'd0, exp_rdy});
            check("cyc_result", {32'd0, bus.data_result}, {32'd0, exp_res});
            check("cyc_exc", {63'd0, bus.data_exception}, {63'd0, exp_exc});
        end
    end

    // Called at a negedge: start is sampled on the following posedge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!bus.data_resultRDY && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        bit seen;
        tests = 0;
        fails = 0;
        chk_en = 1'b0;
        cyc = 0;
        busy = 1'b0;
        done_edge = 0;
        exp_res = '0;
        exp_exc = 1'b0;
        exp_rdy = 1'b0;
        vecs[0] = '{32'd3,        32'd5,        32'h0000000F, 1'b0};
        vecs[1] = '{-32'sd7,      32'd6,        32'hFFFFFFD6, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[3] = '{32'h12345678, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[6] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};

        reset = 1'b1;
        bus.ctrl_MULT = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
        check("reset_result", {32'd0, bus.data_result}, 64'd0);
        check("reset_exc", {63'd0, bus.data_exception}, 64'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b);
            bus.data_operandA = ~vecs[i].a;
            bus.data_operandB = vecs[i].b + 32'd1;
            wait_rdy(n);
            check("vec_latency", 64'(n), 64'd16);
            check("vec_result", {32'd0, bus.data_result}, {32'd0, vecs[i].res});
            check("vec_exc", {63'd0, bus.data_exception}, {63'd0, vecs[i].exc});
            @(negedge clock);
            check("vec_rdy_width", {63'd0, bus.data_resultRDY}, 64'd0);
        end

        // Start pulse during RUN must be ignored.
        start_op(32'h1111, 32'd3);
        repeat (4) @(negedge clock);
        start_op(32'h55, 32'h77);
        bus.data_operandA = 32'hDEADBEEF;
        wait_rdy(n);
        check("ign_latency", 64'(n), 64'd11);
        check("ign_result", {32'd0, bus.data_result}, 64'h3333);
        @(negedge clock);

        // Reset mid-RUN: no strobe, outputs cleared.
        start_op(32'd9, 32'd9);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
        check("midrst_result", {32'd0, bus.data_result}, 64'd0);
        check("midrst_exc", {63'd0, bus.data_exception}, 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.data_resultRDY) seen = 1'b1;
        end
        check("midrst_no_rdy", {63'd0, seen}, 64'd0);
        start_op(32'd4, -32'sd4);
        wait_rdy(n);
        check("post_rst_latency", 64'(n), 64'd16);
        check("post_rst_result", {32'd0, bus.data_result}, 64'hFFFFFFF0);
        @(negedge clock);

        // Back-to-back start in the DONE cycle.
        start_op(32'd2, 32'd3);
        wait_rdy(n);
        check("b2b_first", {32'd0, bus.data_result}, 64'd6);
        start_op(32'd100, 32'd100);
        check("b2b_rdy_drop", {63'd0, bus.data_resultRDY}, 64'd0);
        repeat (5) @(negedge clock);
        check("b2b_hold", {32'd0, bus.data_result}, 64'd6);
        wait_rdy(n);
        check("b2b_latency", 64'(n + 5), 64'd16);
        check("b2b_second", {32'd0, bus.data_result}, 64'h2710);
        check("b2b_exc", {63'd0, bus.data_exception}, 64'd0);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
